// File: rtl/bram_block_reader.sv
// Drains one NUM_BLOCKS-block number from a BRAM read port as a valid/ready block stream, LSB block first.
// Reads are credit-limited so every in-flight BRAM word has a guaranteed FIFO slot when it returns.
module bram_block_reader #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = READ_LATENCY + 2,
  localparam int AW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  output logic [AW-1:0]            bram_addr_out,
  output logic                     bram_en_out,
  input  logic [REGISTER_SIZE-1:0] bram_dout_in,
  output logic [REGISTER_SIZE-1:0] block_out,
  output logic                     block_valid_out,
  output logic                     block_last_out,
  input  logic                     block_ready_in,
  output logic                     busy_out,
  output logic                     done_out
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            cnt_q, cnt_d;
  logic [READ_LATENCY-1:0]  vld_pipe_q, last_pipe_q;
  logic [REGISTER_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    mem_last_q;
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            fcnt_q;
  logic                     issue, push, pop, credit_ok;
  int                       in_flight;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit is taken from registered counts only; a pop frees its slot next cycle.
  always_comb begin
    in_flight = 0;
    for (int i = 0; i < READ_LATENCY; i++) in_flight += int'(vld_pipe_q[i]);
  end

  assign credit_ok       = (in_flight + int'(fcnt_q)) < FIFO_DEPTH;
  assign push            = vld_pipe_q[READ_LATENCY-1];
  assign block_valid_out = (fcnt_q != '0);
  assign pop             = block_valid_out & block_ready_in;
  assign block_out       = mem_q[rd_ptr_q];
  assign block_last_out  = block_valid_out & mem_last_q[rd_ptr_q];
  assign bram_en_out     = issue;
  assign bram_addr_out   = cnt_q;
  assign busy_out        = (state_q != IDLE);
  assign done_out        = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (start_in) begin
        state_d = ISSUE;
        cnt_d   = '0;
      end
      ISSUE: if (credit_ok) begin
        issue = 1'b1;
        // Counter parks on the last address so the address output holds while idle.
        if (cnt_q == LAST_ADDR) state_d = DRAIN;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      DRAIN: if (pop && block_last_out) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      mem_last_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
      vld_pipe_q[0]  <= issue;
      last_pipe_q[0] <= issue && (cnt_q == LAST_ADDR);
      if (push) begin
        mem_q[wr_ptr_q]      <= bram_dout_in;
        mem_last_q[wr_ptr_q] <= last_pipe_q[READ_LATENCY-1];
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_block_reader.sv
// Directed bench: default 128-block reader plus a 1-block, latency-1 instance, each with a BRAM model.
module tb_bram_block_reader;
  localparam int NB = 128;
  localparam logic [31:0] B = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_m, ready_m, en_m, vld_m, last_m, busy_m, done_m;
  logic [6:0]  addr_m;
  logic [31:0] dout_m, s0_m, blk_m;
  logic        start_s, ready_s, en_s, vld_s, last_s, busy_s, done_s;
  logic [0:0]  addr_s;
  logic [31:0] dout_s, blk_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start, ready, en;
    logic [6:0]  addr;
    logic        valid;
    logic [31:0] blk;
    logic        last, busy, done;
  } vec_t;
  vec_t vt [13];

  bram_block_reader dut_m (
    .clk_in(clk), .rst_in(rst), .start_in(start_m),
    .bram_addr_out(addr_m), .bram_en_out(en_m), .bram_dout_in(dout_m),
    .block_out(blk_m), .block_valid_out(vld_m), .block_last_out(last_m),
    .block_ready_in(ready_m), .busy_out(busy_m), .done_out(done_m)
  );

  bram_block_reader #(.REGISTER_SIZE(32), .NUM_BLOCKS(1), .READ_LATENCY(1)) dut_s (
    .clk_in(clk), .rst_in(rst), .start_in(start_s),
    .bram_addr_out(addr_s), .bram_en_out(en_s), .bram_dout_in(dout_s),
    .block_out(blk_s), .block_valid_out(vld_s), .block_last_out(last_s),
    .block_ready_in(ready_s), .busy_out(busy_s), .done_out(done_s)
  );

  // BRAM models: word i = B + i, fixed 2-cycle and 1-cycle read latency.
  always @(posedge clk) begin
    s0_m   <= en_m ? B + 32'(addr_m) : 32'hBAD0_0000;
    dout_m <= s0_m;
    dout_s <= en_s ? B + 32'(addr_s) : 32'hBAD0_0000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic rd, input logic en, input logic [6:0] ad,
                              input logic v, input logic [31:0] b, input logic l,
                              input logic bs, input logic dn);
    vec_t r;
    r.start = st; r.ready = rd; r.en = en; r.addr = ad; r.valid = v;
    r.blk = b; r.last = l; r.busy = bs; r.done = dn;
    return r;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},    32'(en_m),   0);
    chk({tag, "_addr"},  32'(addr_m), 0);
    chk({tag, "_valid"}, 32'(vld_m),  0);
    chk({tag, "_last"},  32'(last_m), 0);
    chk({tag, "_block"}, blk_m,       0);
    chk({tag, "_busy"},  32'(busy_m), 0);
    chk({tag, "_done"},  32'(done_m), 0);
    chk({tag, "_s_en"},  32'(en_s),   0);
    chk({tag, "_s_valid"}, 32'(vld_s), 0);
    chk({tag, "_s_block"}, blk_s,      0);
    chk({tag, "_s_busy"},  32'(busy_s), 0);
  endtask

  // Scoreboard for the rest of a stream: in-order issue and delivery, stall stability, credit bound.
  task automatic stream(input bit rnd, input int xfer0, input int iss0);
    int xfer = xfer0;
    int iss  = iss0;
    bit pv = 1'b0, pr = 1'b0, fin = 1'b0;
    logic [31:0] pb = '0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(posedge clk); #1;
      start_m = 1'b0;
      ready_m = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (en_m) begin
        chk("issue_addr", 32'(addr_m), 32'(iss));
        iss++;
      end
      chk("credit_bound", 32'((iss - xfer) <= 4), 1);
      if (pv && !pr) begin
        chk("hold_valid", 32'(vld_m), 1);
        chk("hold_block", blk_m, pb);
      end
      chk("busy", 32'(busy_m), 1);
      if (vld_m && ready_m) begin
        chk("block", blk_m, B + 32'(xfer));
        chk("last", 32'(last_m), 32'(xfer == NB - 1));
        xfer++;
      end
      if (done_m) begin
        chk("done_count", 32'(xfer), NB);
        chk("issue_count", 32'(iss), NB);
        fin = 1'b1;
      end
      pv = vld_m; pr = ready_m; pb = blk_m;
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL stream_timeout: got no done_out, expected done after %0d blocks", NB);
    end
  endtask

  initial begin
    rst = 1'b1; start_m = 1'b0; ready_m = 1'b0; start_s = 1'b0; ready_s = 1'b0;
    vt[0]  = mk(1, 0, 0, 0, 0, 0,     0, 0, 0);
    vt[1]  = mk(0, 0, 1, 0, 0, 0,     0, 1, 0);
    vt[2]  = mk(0, 0, 1, 1, 0, 0,     0, 1, 0);
    vt[3]  = mk(0, 0, 1, 2, 0, 0,     0, 1, 0);
    vt[4]  = mk(0, 0, 1, 3, 1, B,     0, 1, 0);
    vt[5]  = mk(0, 0, 0, 0, 1, B,     0, 1, 0);
    vt[6]  = mk(0, 0, 0, 0, 1, B,     0, 1, 0);
    vt[7]  = mk(0, 0, 0, 0, 1, B,     0, 1, 0);
    vt[8]  = mk(0, 1, 0, 0, 1, B,     0, 1, 0);
    vt[9]  = mk(0, 1, 1, 4, 1, B + 1, 0, 1, 0);
    vt[10] = mk(0, 1, 1, 5, 1, B + 2, 0, 1, 0);
    vt[11] = mk(0, 1, 1, 6, 1, B + 3, 0, 1, 0);
    vt[12] = mk(0, 1, 1, 7, 1, B + 4, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("init");

    // Back-to-back with ready=1; restarts mid-stream and in the done cycle must be ignored.
    ready_m = 1'b1;
    for (int c = 0; c <= 133; c++) begin
      @(posedge clk); #1;
      start_m = (c == 0 || c == 50 || c == 132 || c == 133);
      @(negedge clk);
      chk($sformatf("b2b_en@%0d", c), 32'(en_m), 32'(c >= 1 && c <= NB));
      if (c >= 1 && c <= NB) chk($sformatf("b2b_addr@%0d", c), 32'(addr_m), 32'(c - 1));
      chk($sformatf("b2b_valid@%0d", c), 32'(vld_m), 32'(c >= 4 && c <= NB + 3));
      if (c >= 4 && c <= NB + 3) begin
        chk($sformatf("b2b_block@%0d", c), blk_m, B + 32'(c - 4));
        chk($sformatf("b2b_last@%0d", c), 32'(last_m), 32'(c == NB + 3));
      end
      chk($sformatf("b2b_busy@%0d", c), 32'(busy_m), 32'(c >= 1 && c <= NB + 4));
      chk($sformatf("b2b_done@%0d", c), 32'(done_m), 32'(c == NB + 4));
    end
    // Start driven one cycle after done was accepted; drain it under random backpressure.
    stream(1'b1, 0, 0);

    // Stalled from the start: exactly four reads, head held, then release.
    for (int r = 0; r < 13; r++) begin
      @(posedge clk); #1;
      start_m = vt[r].start;
      ready_m = vt[r].ready;
      @(negedge clk);
      chk($sformatf("vec%0d_en", r), 32'(en_m), 32'(vt[r].en));
      if (vt[r].en) chk($sformatf("vec%0d_addr", r), 32'(addr_m), 32'(vt[r].addr));
      chk($sformatf("vec%0d_valid", r), 32'(vld_m), 32'(vt[r].valid));
      if (vt[r].valid) begin
        chk($sformatf("vec%0d_block", r), blk_m, vt[r].blk);
        chk($sformatf("vec%0d_last", r), 32'(last_m), 32'(vt[r].last));
      end
      chk($sformatf("vec%0d_busy", r), 32'(busy_m), 32'(vt[r].busy));
      chk($sformatf("vec%0d_done", r), 32'(done_m), 32'(vt[r].done));
    end
    stream(1'b0, 5, 8);

    // Reset two cycles after the first issue; returning BRAM data must be dropped.
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      start_m = (c == 0);
      rst     = (c == 3);
      ready_m = 1'b1;
      @(negedge clk);
      if (c == 1) chk("rst_first_issue", 32'(en_m), 1);
      if (c == 4) chk_reset("midrst");
      if (c > 4) begin
        chk($sformatf("rst_valid@%0d", c), 32'(vld_m), 0);
        chk($sformatf("rst_en@%0d", c), 32'(en_m), 0);
      end
    end
    @(posedge clk); #1;
    start_m = 1'b1;
    @(negedge clk);
    chk("rst_restart_idle", 32'(busy_m), 0);
    stream(1'b0, 0, 0);

    // Single block, latency 1.
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      start_s = (c == 0);
      ready_s = 1'b1;
      @(negedge clk);
      chk($sformatf("one_en@%0d", c), 32'(en_s), 32'(c == 1));
      if (c == 1) chk("one_addr", 32'(addr_s), 0);
      chk($sformatf("one_valid@%0d", c), 32'(vld_s), 32'(c == 3));
      if (c == 3) begin
        chk("one_block", blk_s, B);
        chk("one_last", 32'(last_s), 1);
      end
      chk($sformatf("one_busy@%0d", c), 32'(busy_s), 32'(c >= 1 && c <= 4));
      chk($sformatf("one_done@%0d", c), 32'(done_s), 32'(c == 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
